// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//
// Instruction-fetch sequencer for an RV32I pipeline. It owns the program
// counter, issues word-aligned requests to instruction memory over a
// request/acknowledge handshake, and presents each fetched word to decode
// together with its PC and PC+4. Decode stalls and branch/jump redirects
// (including redirects that land while a request is outstanding) are absorbed
// here, so a squashed instruction never reaches decode with if_valid=1.
//
// Parameters:
//   RESET_PC     PC of the first fetch after reset
//   NOP_INST     value shown on if_inst while in reset
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   stall          in   decode not accepting; hold the presented instruction
//   redirect       in   one-cycle taken branch/jump pulse from execute
//   redirect_addr  in   redirect target (bits [1:0] ignored)
//   imem_req       out  fetch request, held until imem_ack
//   imem_addr      out  fetch address, stable while imem_req=1
//   imem_ack       in   one-cycle completion, imem_rdata valid this cycle
//   imem_rdata     in   fetched instruction word
//   if_valid       out  if_inst / if_pc / if_pc4 valid for decode
//   if_inst        out  fetched instruction
//   if_pc          out  address of if_inst
//   if_pc4         out  if_pc + 4 (modulo 2^32)
//   fetch_count    out  instructions accepted by decode (modulo 2^32)
//   fsm_state      out  current FSM state (0 idle, 1 req, 2 drop, 3 valid)
//
// Handshakes: a memory transaction completes on any rising edge where
// imem_req=1 and imem_ack=1; imem_ack is ignored while imem_req=0. Decode
// accepts the presented instruction on any edge with if_valid=1, stall=0
// and redirect=0.
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] fetch_count,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DROP  = 2'd2,
        S_VALID = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] target, target_n;
    logic        req_n;
    logic [31:0] addr_n;
    logic        valid_n;
    logic [31:0] inst_n, ipc_n, ipc4_n, count_n;
    logic [31:0] redir_word;
    logic        mem_done;

    assign redir_word = {redirect_addr[31:2], 2'b00};
    assign mem_done   = imem_req & imem_ack;
    assign fsm_state  = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            target      <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            if_valid    <= 1'b0;
            if_inst     <= NOP_INST;
            if_pc       <= RESET_PC;
            if_pc4      <= RESET_PC + 32'd4;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            target      <= target_n;
            imem_req    <= req_n;
            imem_addr   <= addr_n;
            if_valid    <= valid_n;
            if_inst     <= inst_n;
            if_pc       <= ipc_n;
            if_pc4      <= ipc4_n;
            fetch_count <= count_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        target_n = target;
        req_n    = imem_req;
        addr_n   = imem_addr;
        valid_n  = if_valid;
        inst_n   = if_inst;
        ipc_n    = if_pc;
        ipc4_n   = if_pc4;
        count_n  = fetch_count;

        case (state)
            S_IDLE: begin
                state_n = S_REQ;
                req_n   = 1'b1;
                addr_n  = pc;
            end

            S_REQ: begin
                if (mem_done) begin
                    if (redirect) begin
                        // Data belongs to the squashed path; restart the
                        // request at the target without leaving S_REQ.
                        pc_n   = redir_word;
                        addr_n = redir_word;
                    end else begin
                        inst_n  = imem_rdata;
                        ipc_n   = imem_addr;
                        ipc4_n  = imem_addr + 32'd4;
                        valid_n = 1'b1;
                        pc_n    = imem_addr + 32'd4;
                        req_n   = 1'b0;
                        state_n = S_VALID;
                    end
                end else if (redirect) begin
                    // The request cannot be withdrawn; remember where to go
                    // and wait out the old transaction.
                    target_n = redir_word;
                    state_n  = S_DROP;
                end
            end

            S_DROP: begin
                if (mem_done) begin
                    pc_n    = redirect ? redir_word : target;
                    addr_n  = redirect ? redir_word : target;
                    state_n = S_REQ;
                end else if (redirect) begin
                    target_n = redir_word;
                end
            end

            S_VALID: begin
                if (redirect) begin
                    valid_n = 1'b0;
                    pc_n    = redir_word;
                    addr_n  = redir_word;
                    req_n   = 1'b1;
                    state_n = S_REQ;
                end else if (!stall) begin
                    count_n = fetch_count + 32'd1;
                    valid_n = 1'b0;
                    addr_n  = pc;
                    req_n   = 1'b1;
                    state_n = S_REQ;
                end
            end

            default: begin
                state_n = S_IDLE;
                req_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the instruction-fetch stage of the RV32I pipeline. Owns the program counter, drives a request/acknowledge handshake to instruction memory, and presents each fetched instruction with its PC and PC+4 to the decode stage. It absorbs decode stalls and branch/jump redirects, including redirects that arrive while a memory request is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- NOP_INST, 32'h0000_0013, value of if_inst at reset (addi x0,x0,0)
- clock  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  decode not accepting; holds the presented instruction
- redirect  in  1  taken branch/jump from execute; one-cycle pulse
- redirect_addr  in  32  redirect target; bits [1:0] forced to 0
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1
- imem_ack  in  1  one-cycle completion; imem_rdata valid in this cycle
- imem_rdata  in  32  fetched instruction word
- if_valid  out  1  if_inst/if_pc/if_pc4 valid for decode
- if_inst  out  32  fetched instruction
- if_pc  out  32  address of if_inst
- if_pc4  out  32  if_pc + 4
- fetch_count  out  32  number of instructions accepted by decode

## Operation
- All outputs registered. Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, if_pc4=RESET_PC+4, fetch_count=0; internal pc=RESET_PC, state=S_IDLE.
- Transaction completes on any cycle with imem_req=1 and imem_ack=1. imem_ack is ignored when imem_req=0.
- S_IDLE: imem_req=0. Moves unconditionally to S_REQ on the next edge; imem_req=1, imem_addr=pc.
- S_REQ: imem_req=1, address held.
  - ack and no redirect: capture if_inst=imem_rdata, if_pc=imem_addr, if_pc4=imem_addr+4; if_valid=1; pc=imem_addr+4; imem_req=0; go to S_VALID.
  - ack and redirect in the same cycle: discard data; pc=imem_addr=redirect_addr; stay in S_REQ. A new transaction begins next cycle.
  - redirect without ack: latch target=redirect_addr; go to S_DROP. imem_addr is not changed.
- S_DROP: imem_req=1 with the old address until ack. A further redirect overwrites target (last wins). On ack, discard data; pc=imem_addr=target (or redirect_addr if a redirect coincides with the ack); go to S_REQ.
- S_VALID: imem_req=0, if_valid=1. Priority is redirect > stall > accept.
  - redirect: if_valid=0; pc=imem_addr=redirect_addr; go to S_REQ. Not counted.
  - stall: hold all if_* outputs; stay.
  - accept (stall=0): fetch_count+1; if_valid=0; imem_addr=pc; go to S_REQ.
- While if_valid=0, if_inst/if_pc/if_pc4 keep their last captured values.
- Arithmetic:
  - PC+4 and fetch_count are modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
  - redirect_addr[1:0] is treated as 2'b00 everywhere.
- Reset asserted mid-operation immediately forces the reset values. A pending memory response is then lost; an ack arriving in S_IDLE is ignored.

## Timing
- First request is asserted on the second rising edge after reset deasserts (one cycle in S_IDLE).
- Zero-wait memory (ack in the first request cycle) with no stalls: one instruction every 2 cycles (S_REQ, S_VALID).
- Memory with N wait cycles: 2+N cycles per instruction.
- Redirect to new request address:
  - 1 cycle from S_VALID or from S_REQ with coincident ack.
  - From S_REQ without ack: the ack cycle of the abandoned request plus 1.
- Redirect never causes a discarded or stale instruction to be presented with if_valid=1.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0093 at address 0 → imem_req rises on the 2nd edge with imem_addr=0. Next cycle: if_valid=1, if_inst=32'h0000_0093, if_pc=0, if_pc4=4. Then imem_addr=4.
- Stall held 3 cycles with if_valid=1 at if_pc=8 → outputs unchanged, fetch_count unchanged, imem_req=0. On release, fetch_count+1 and the next imem_addr=12.
- Memory with 3 wait cycles at address 0x10, redirect to 0x203 in wait cycle 1 → imem_addr stays 0x10 until ack, data discarded, next request at 0x200, if_valid never 1 for 0x10.
- Two redirects (0x40, then 0x80) during one outstanding request → only 0x80 fetched afterwards.
- Redirect and stall together in S_VALID → if_valid drops, next request at the redirect target, fetch_count unchanged.
- RESET_PC=32'hFFFF_FFFC → first if_pc4=0 and second fetch at 0. Asserting reset during an outstanding request clears everything, and a late ack is ignored.
